stream_mux: RTL and testbench

Parametrised N-channel, W-bit streaming multiplexer with valid/ready handshake, packet-locked arbitration and a registered output stage. It generalises the combinational 4:1 select into a block that selects its source itself, by fixed priority or round-robin, and holds that source for a whole packet. It sits between multiple packet producers and one shared downstream consumer, such as a shared UART or display bus.

---
 rtl/stream_mux_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/stream_mux.sv | 116 +++++++++++
 tb/tb_stream_mux.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the packet-locked stream multiplexer.
package stream_mux_pkg;

  typedef enum logic {IDLE, LOCKED} stream_mux_state_t;

  localparam int unsigned MODE_FIXED = 0;
  localparam int unsigned MODE_RR    = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: fixed priority from index 0, or round-robin starting at ptr.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             mode,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] start;
  logic             hi_any;
  logic [SEL_W-1:0] hi_idx;
  logic             lo_any;
  logic [SEL_W-1:0] lo_idx;

  assign start = mode ? ptr : '0;

  // Two passes emulate the wrap: first hit at or above start, else first hit overall.
  always_comb begin
    hi_any = 1'b0;
    hi_idx = '0;
    lo_any = 1'b0;
    lo_idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (!hi_any && req[i] && (i >= int'(start))) begin
        hi_any = 1'b1;
        hi_idx = SEL_W'(i);
      end
      if (!lo_any && req[i]) begin
        lo_any = 1'b1;
        lo_idx = SEL_W'(i);
      end
    end
  end

  assign any = lo_any;
  assign idx = hi_any ? hi_idx : lo_idx;

endmodule

// File: rtl/stream_mux.sv
// N-channel valid/ready stream mux that holds its chosen source for a whole packet
// and drives a single registered output stage.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned MODE  = 1,
  parameter int unsigned SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_last,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic             out_last,
  output logic [SEL_W-1:0] out_sel,
  input  logic             out_ready
);

  stream_mux_state_t state_q, state_d;
  logic [SEL_W-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic              out_valid_q;
  logic [W-1:0]      out_data_q;
  logic              out_last_q;
  logic [SEL_W-1:0]  out_sel_q;

  logic             slot_free;
  logic             arb_any;
  logic [SEL_W-1:0] arb_idx;
  logic [SEL_W-1:0] acc_idx;
  logic             acc_en;
  logic [N-1:0]     rdy;
  logic             accept;
  logic [W-1:0]     acc_data;
  logic             acc_last;

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req  (in_valid),
    .ptr  (ptr_q),
    .mode (MODE == MODE_RR),
    .any  (arb_any),
    .idx  (arb_idx)
  );

  always_comb begin
    slot_free = !out_valid_q || out_ready;
    acc_idx   = (state_q == IDLE) ? arb_idx : gnt_q;
    acc_en    = (state_q == IDLE) ? (arb_any && slot_free) : slot_free;
    rdy       = '0;
    acc_data  = '0;
    acc_last  = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (acc_idx == SEL_W'(i)) begin
        rdy[i]   = acc_en;
        acc_data = in_data[i*W +: W];
        acc_last = in_last[i];
      end
    end
    accept = |(rdy & in_valid);
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    if (accept) begin
      gnt_d = acc_idx;
      if (acc_last) begin
        state_d = IDLE;
        ptr_d   = (acc_idx == SEL_W'(N - 1)) ? '0 : acc_idx + 1'b1;
      end else begin
        state_d = LOCKED;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= acc_data;
        out_last_q  <= acc_last;
        out_sel_q   <= acc_idx;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Hold in_ready low while reset is asserted so no upstream beat is lost.
  assign in_ready  = rdy & {N{rst_n}};
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux.sv
// Bench for stream_mux: a fixed-priority and a round-robin instance share stimulus and
// are each compared every cycle against a packet-level model, plus directed literal checks.
module tb_stream_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic        out_ready;

  logic [3:0] rdy_fx, rdy_rr;
  logic       ov_fx, ov_rr, ol_fx, ol_rr;
  logic [7:0] od_fx, od_rr;
  logic [1:0] os_fx, os_rr;

  int total = 0;
  int bad   = 0;

  // Model: owner = channel holding an open packet (-1 none), ptr = round-robin start.
  int m_owner[2];
  int m_ptr[2];
  int m_ov[2];
  int m_od[2];
  int m_ol[2];
  int m_os[2];

  logic [7:0] obs_rr[$];

  stream_mux #(.N(4), .W(8), .MODE(0)) u_fx (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy_fx), .out_valid(ov_fx), .out_data(od_fx), .out_last(ol_fx),
    .out_sel(os_fx), .out_ready(out_ready)
  );

  stream_mux #(.N(4), .W(8), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy_rr), .out_valid(ov_rr), .out_data(od_rr), .out_last(ol_rr),
    .out_sel(os_rr), .out_ready(out_ready)
  );

  initial forever #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = -1;
      m_ptr[m]   = 0;
      m_ov[m]    = 0;
      m_od[m]    = 0;
      m_ol[m]    = 0;
      m_os[m]    = 0;
    end
  endtask

  function automatic int exp_rdy(int m);
    int start;
    if (!(m_ov[m] == 0 || out_ready)) return 0;
    if (m_owner[m] >= 0) return 1 << m_owner[m];
    start = (m == 1) ? m_ptr[m] : 0;
    for (int k = 0; k < 4; k++) begin
      if (in_valid[(start + k) % 4]) return 1 << ((start + k) % 4);
    end
    return 0;
  endfunction

  task automatic step(int m);
    int r;
    int ch;
    r  = exp_rdy(m);
    ch = -1;
    for (int c = 0; c < 4; c++) if (r[c] && in_valid[c]) ch = c;
    if (ch >= 0) begin
      m_ov[m] = 1;
      m_od[m] = int'(in_data[ch*8 +: 8]);
      m_ol[m] = int'(in_last[ch]);
      m_os[m] = ch;
      if (in_last[ch]) begin
        m_owner[m] = -1;
        m_ptr[m]   = (ch + 1) % 4;
      end else begin
        m_owner[m] = ch;
      end
    end else if (out_ready) begin
      m_ov[m] = 0;
    end
  endtask

  task automatic compare(int m);
    string n;
    n = (m == 1) ? "rr" : "fx";
    check({n, "_in_ready"},  (m == 1) ? rdy_rr : rdy_fx, rst_n ? exp_rdy(m) : 0);
    check({n, "_out_valid"}, (m == 1) ? ov_rr : ov_fx, m_ov[m]);
    check({n, "_out_data"},  (m == 1) ? od_rr : od_fx, m_od[m]);
    check({n, "_out_last"},  (m == 1) ? ol_rr : ol_fx, m_ol[m]);
    check({n, "_out_sel"},   (m == 1) ? os_rr : os_fx, m_os[m]);
  endtask

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    compare(0);
    compare(1);
    if (rst_n) begin
      step(0);
      step(1);
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov_rr && out_ready) obs_rr.push_back(od_rr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted mid-cycle: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_ov_rr", ov_rr, 0);
    check("rst_od_rr", od_rr, 0);
    check("rst_os_rr", os_rr, 0);
    check("rst_rdy_rr", rdy_rr, 0);
    check("rst_ov_fx", ov_fx, 0);
    check("rst_rdy_fx", rdy_fx, 0);
    in_valid = '0;
    in_last  = '0;
    tick();
    tick();
    rst_n = 1'b1;
    obs_rr.delete();
  endtask

  task automatic check_obs(string name, logic [31:0] exp);
    logic [7:0] e[4];
    e[0] = exp[31:24];
    e[1] = exp[23:16];
    e[2] = exp[15:8];
    e[3] = exp[7:0];
    check({name, "_count"}, obs_rr.size(), 4);
    for (int i = 0; i < 4 && i < obs_rr.size(); i++) check({name, "_beat"}, obs_rr[i], e[i]);
  endtask

  initial begin
    logic [7:0] cap_d;
    logic [1:0] cap_s;
    logic [7:0] beats[3];
    int k;
    int cyc;
    int gap;
    logic acc;

    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    out_ready = 1'b1;
    model_reset();
    tick();
    tick();
    tick();
    rst_n = 1'b1;

    // Single beat from channel 2 appears one cycle later.
    in_valid = 4'b0100;
    in_data  = 32'h00A5_0000;
    in_last  = 4'b0100;
    tick();
    check("first_ov", ov_rr, 1);
    check("first_data", od_rr, 8'hA5);
    check("first_sel", os_rr, 2);
    check("first_last", ol_rr, 1);
    check("first_sel_fx", os_fx, 2);
    do_reset();

    // Round-robin fairness with 1-beat packets on all channels.
    in_valid = 4'hF;
    in_last  = 4'hF;
    in_data  = 32'h4433_2211;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rr_sel", os_rr, i % 4);
      check("rr_valid", ov_rr, 1);
      check("rr_data", od_rr, 8'h11 * ((i % 4) + 1));
      check("fx_sel_all", os_fx, 0);
    end

    // Fixed priority: channel 1 starves channel 3.
    in_valid = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("fx_sel", os_fx, 1);
      check("fx_valid", ov_fx, 1);
      check("fx_rdy", rdy_fx, 4'b0010);
    end
    do_reset();

    // Packet lock: ch0 3-beat packet, ch1 waiting from cycle 1.
    beats[0] = 8'h11;
    beats[1] = 8'h22;
    beats[2] = 8'h33;
    k   = 0;
    cyc = 0;
    while (k < 3 && cyc < 20) begin
      in_valid[0]      = 1'b1;
      in_data[7:0]     = beats[k];
      in_last[0]       = (k == 2);
      in_valid[1]      = (cyc >= 1);
      in_data[15:8]    = 8'h77;
      in_last[1]       = 1'b1;
      @(negedge clk);
      acc = rdy_rr[0];
      if (cyc >= 1) check("lock_rdy1", rdy_rr[1], 0);
      @(posedge clk);
      #1;
      if (acc) k++;
      cyc++;
    end
    check("lock_done", k, 3);
    in_valid[0] = 1'b0;
    cyc = 0;
    acc = 1'b0;
    while (!acc && cyc < 20) begin
      @(negedge clk);
      acc = rdy_rr[1];
      @(posedge clk);
      #1;
      cyc++;
    end
    check("lock_ch1_served", acc, 1);
    in_valid = '0;
    tick();
    tick();
    check_obs("lock_obs", 32'h1122_3377);
    do_reset();

    // Backpressure: out_* frozen and in_ready low while stalled.
    in_valid = 4'hF;
    in_last  = 4'hF;
    in_data  = 32'h4433_2211;
    tick();
    tick();
    out_ready = 1'b0;
    cap_d = od_rr;
    cap_s = os_rr;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", ov_rr, 1);
      check("bp_data", od_rr, cap_d);
      check("bp_sel", os_rr, cap_s);
      check("bp_rdy_rr", rdy_rr, 0);
      check("bp_rdy_fx", rdy_fx, 0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_resume", os_rr, (cap_s + 1) % 4);
    do_reset();

    // Gap in a locked ch2 packet while ch0 is waiting.
    beats[0] = 8'h21;
    beats[1] = 8'h22;
    beats[2] = 8'h23;
    k   = 0;
    cyc = 0;
    gap = 0;
    while (k < 3 && cyc < 20) begin
      in_valid[2]    = !(k == 1 && gap < 2);
      in_data[23:16] = beats[k];
      in_last[2]     = (k == 2);
      in_valid[0]    = (cyc >= 1);
      in_data[7:0]   = 8'h0A;
      in_last[0]     = 1'b1;
      @(negedge clk);
      acc = rdy_rr[2] && in_valid[2];
      check("gap_rdy0", rdy_rr[0], 0);
      if (!in_valid[2]) check("gap_no_beat_fx", rdy_fx[0], 0);
      @(posedge clk);
      #1;
      if (!in_valid[2]) gap++;
      if (acc) k++;
      cyc++;
    end
    check("gap_done", k, 3);
    in_valid[2] = 1'b0;
    cyc = 0;
    acc = 1'b0;
    while (!acc && cyc < 20) begin
      @(negedge clk);
      acc = rdy_rr[0];
      @(posedge clk);
      #1;
      cyc++;
    end
    check("gap_ch0_served", acc, 1);
    in_valid = '0;
    tick();
    tick();
    check_obs("gap_obs", 32'h2122_230A);
    do_reset();

    // Random traffic, including mid-packet valid drops and backpressure.
    for (int i = 0; i < 3000; i++) begin
      in_valid = 4'($urandom);
      in_data  = $urandom;
      for (int c = 0; c < 4; c++) in_last[c] = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (i == 1500) begin
        do_reset();
      end else begin
        tick();
      end
    end

    in_valid  = '0;
    out_ready = 1'b1;
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
